// File: rtl/pid_scheduler.sv
// Round-robin scheduler that time-multiplexes one pid core across NCH channels.
// Latches per-channel samples, issues a start pulse, waits PID_LAT cycles, returns a tagged result.
module pid_scheduler #(
  parameter  int unsigned NCH     = 4,
  parameter  int unsigned PID_LAT = 4,
  localparam int unsigned CW      = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NCH-1:0]    req,
  input  logic [16*NCH-1:0] data_in,
  input  logic              ovr_clr,
  output logic              pid_start,
  output logic [15:0]       pid_data_in,
  output logic [CW-1:0]     pid_ch,
  input  logic [15:0]       pid_data_out,
  output logic              res_valid,
  output logic [CW-1:0]     res_ch,
  output logic [15:0]       res_data,
  output logic              busy,
  output logic [NCH-1:0]    overrun
);

  localparam int unsigned CNTW = $clog2(PID_LAT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [NCH-1:0]    pending_q, pending_d;
  logic [NCH-1:0]    ovr_q, ovr_d;
  logic [15:0]       sample_q [NCH];
  logic [15:0]       sample_d [NCH];
  logic              pid_start_q, pid_start_d;
  logic [15:0]       pid_data_in_q, pid_data_in_d;
  logic [CW-1:0]     pid_ch_q, pid_ch_d;
  logic              res_valid_q, res_valid_d;
  logic [CW-1:0]     res_ch_q, res_ch_d;
  logic [15:0]       res_data_q, res_data_d;

  logic              grant_vld;
  logic [CW-1:0]     grant_ch;
  logic [CW-1:0]     cand;
  logic              grant;
  logic [NCH-1:0]    grant_mask;
  logic [NCH-1:0]    new_ovr;

  // First pending channel at or after ptr, wrapping modulo NCH.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand = CW'((32'(ptr_q) + i) % NCH);
      if (!grant_vld && pending_q[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
    end
  end

  assign grant      = (state_q == S_IDLE) && enable && grant_vld;
  assign grant_mask = grant ? (NCH'(1) << grant_ch) : '0;

  // A request on the granting edge re-arms pending without counting as an overrun.
  always_comb begin
    new_ovr   = req & pending_q & ~grant_mask;
    pending_d = (pending_q & ~grant_mask) | req;
    ovr_d     = (ovr_q & ~{NCH{ovr_clr}}) | new_ovr;
    for (int unsigned c = 0; c < NCH; c++) begin
      sample_d[c] = req[c] ? data_in[16*c +: 16] : sample_q[c];
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    pid_start_d   = 1'b0;
    pid_data_in_d = pid_data_in_q;
    pid_ch_d      = pid_ch_q;
    res_valid_d   = 1'b0;
    res_ch_d      = res_ch_q;
    res_data_d    = res_data_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          ptr_d         = CW'((32'(grant_ch) + 1) % NCH);
          pid_data_in_d = sample_q[grant_ch];
          pid_ch_d      = grant_ch;
          pid_start_d   = 1'b1;
          cnt_d         = '0;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNTW'(PID_LAT)) begin
          res_data_d  = pid_data_out;
          res_ch_d    = pid_ch_q;
          res_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ptr_q         <= '0;
      pending_q     <= '0;
      ovr_q         <= '0;
      pid_start_q   <= 1'b0;
      pid_data_in_q <= '0;
      pid_ch_q      <= '0;
      res_valid_q   <= 1'b0;
      res_ch_q      <= '0;
      res_data_q    <= '0;
      for (int unsigned c = 0; c < NCH; c++) begin
        sample_q[c] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      pending_q     <= pending_d;
      ovr_q         <= ovr_d;
      pid_start_q   <= pid_start_d;
      pid_data_in_q <= pid_data_in_d;
      pid_ch_q      <= pid_ch_d;
      res_valid_q   <= res_valid_d;
      res_ch_q      <= res_ch_d;
      res_data_q    <= res_data_d;
      for (int unsigned c = 0; c < NCH; c++) begin
        sample_q[c] <= sample_d[c];
      end
    end
  end

  assign pid_start   = pid_start_q;
  assign pid_data_in = pid_data_in_q;
  assign pid_ch      = pid_ch_q;
  assign res_valid   = res_valid_q;
  assign res_ch      = res_ch_q;
  assign res_data    = res_data_q;
  assign busy        = (state_q == S_WAIT);
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_pid_scheduler.sv
// Scoreboard bench for pid_scheduler with a delay-line stub standing in for the pid core.
module tb_pid_scheduler;

  localparam int unsigned NCH     = 4;
  localparam int unsigned PID_LAT = 4;
  localparam int unsigned CW      = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [NCH-1:0]    req;
  logic [16*NCH-1:0] data_in;
  logic              ovr_clr;
  logic              pid_start;
  logic [15:0]       pid_data_in;
  logic [CW-1:0]     pid_ch;
  logic [15:0]       pid_data_out;
  logic              res_valid;
  logic [CW-1:0]     res_ch;
  logic [15:0]       res_data;
  logic              busy;
  logic [NCH-1:0]    overrun;

  logic [15:0] lane [NCH];
  logic [15:0] pipe [PID_LAT];

  typedef struct {
    int ch;
    int data;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  pid_scheduler #(.NCH(NCH), .PID_LAT(PID_LAT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .data_in(data_in),
    .ovr_clr(ovr_clr), .pid_start(pid_start), .pid_data_in(pid_data_in),
    .pid_ch(pid_ch), .pid_data_out(pid_data_out), .res_valid(res_valid),
    .res_ch(res_ch), .res_data(res_data), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign data_in = {lane[3], lane[2], lane[1], lane[0]};

  // Core stub: sum captured on the start edge, presented PID_LAT edges later.
  always @(posedge clk) begin
    pipe[0] <= pid_start ? (pid_data_in + 16'(pid_ch)) : 16'hDEAD;
    for (int i = 1; i < PID_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign pid_data_out = pipe[PID_LAT-1];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && res_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got ch=%0d data=%0d at cycle %0d, expected none",
                 res_ch, res_data, cyc);
      end else begin
        mon_e = q.pop_front();
        check("res_ch", int'(res_ch), mon_e.ch);
        check("res_data", int'(res_data), mon_e.data);
        check("res_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input int ch, input int data, input int c);
    exp_t e;
    e.ch = ch;
    e.data = data;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic do_req(input logic [NCH-1:0] mask, output int e0);
    req = mask;
    step();
    req = '0;
    e0 = cyc;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || busy) && t < 300) begin
      step();
      t++;
    end
    if (t >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got %0d outstanding, expected 0", q.size());
    end
    step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_pid_start"}, int'(pid_start), 0);
    check({tag, "_pid_data_in"}, int'(pid_data_in), 0);
    check({tag, "_pid_ch"}, int'(pid_ch), 0);
    check({tag, "_res_valid"}, int'(res_valid), 0);
    check({tag, "_res_ch"}, int'(res_ch), 0);
    check({tag, "_res_data"}, int'(res_data), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    int e0;
    int n;
    int bad;
    rst = 1'b1;
    enable = 1'b1;
    req = '0;
    ovr_clr = 1'b0;
    for (int i = 0; i < NCH; i++) lane[i] = '0;
    #1 rst = 1'b0;
    #1 check_zero_outputs("reset");
    step();
    step();
    rst = 1'b1;
    step();

    // Reset mid-service: outputs clear immediately, no result afterwards.
    lane[0] = 16'd5;
    do_req(4'b0001, e0);
    step();
    step();
    check("busy_before_reset", int'(busy), 1);
    rst = 1'b0;
    #1 check_zero_outputs("midwait_reset");
    step();
    step();
    rst = 1'b1;
    repeat (12) step();

    // Single request and start-pulse timing.
    lane[0] = 16'd54321;
    do_req(4'b0001, e0);
    expect_res(0, 54321, e0 + 6);
    check("start_before_grant", int'(pid_start), 0);
    step();
    check("start_at_grant", int'(pid_start), 1);
    check("pid_ch_at_grant", int'(pid_ch), 0);
    check("pid_data_at_grant", int'(pid_data_in), 54321);
    step();
    check("start_after_pulse", int'(pid_start), 0);
    check("busy_in_wait", int'(busy), 1);
    wait_idle();

    // All channels at once from ptr=0.
    do_reset();
    lane[0] = 16'd54321; lane[1] = 16'd54326; lane[2] = 16'd54316; lane[3] = 16'd100;
    do_req(4'b1111, e0);
    expect_res(0, 54321, e0 + 6);
    expect_res(1, 54327, e0 + 12);
    expect_res(2, 54318, e0 + 18);
    expect_res(3, 103, e0 + 24);
    wait_idle();

    // Round-robin: after ch1 is granted, ch3 precedes ch0.
    lane[1] = 16'd10;
    do_req(4'b0010, e0);
    expect_res(1, 11, e0 + 6);
    wait_idle();
    lane[0] = 16'd20; lane[3] = 16'd30;
    do_req(4'b1001, e0);
    expect_res(3, 33, e0 + 6);
    expect_res(0, 20, e0 + 12);
    wait_idle();

    // Overrun on ch2 while ch0 is in service; newest sample wins.
    lane[0] = 16'd50;
    do_req(4'b0001, e0);
    expect_res(0, 50, e0 + 6);
    lane[2] = 16'd100;
    do_req(4'b0100, n);
    lane[2] = 16'd200;
    do_req(4'b0100, n);
    expect_res(2, 202, e0 + 12);
    check("overrun_set", int'(overrun), 4);
    wait_idle();
    check("overrun_sticky", int'(overrun), 4);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("overrun_cleared", int'(overrun), 0);

    // Request on the same edge as its grant: old sample served, no overrun.
    lane[1] = 16'd1;
    do_req(4'b0010, e0);
    lane[1] = 16'd2;
    do_req(4'b0010, n);
    check("same_edge_no_overrun", int'(overrun), 0);
    check("same_edge_grant_data", int'(pid_data_in), 1);
    expect_res(1, 2, e0 + 6);
    expect_res(1, 3, e0 + 12);
    wait_idle();

    // Enable gating.
    enable = 1'b0;
    lane[1] = 16'd7;
    do_req(4'b0010, e0);
    bad = 0;
    repeat (20) begin
      step();
      if (pid_start || busy) bad++;
    end
    check("enable_gated_starts", bad, 0);
    enable = 1'b1;
    n = cyc;
    expect_res(1, 8, n + 6);
    step();
    check("enable_grant_next_edge", int'(pid_start), 1);
    wait_idle();

    check("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
